// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      RUN,
      HALT
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries. Flush has priority over push/pop;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_data,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~flush & (~full | pop);
   assign do_pop  = pop & ~flush & ~empty;

   // Storage is data only; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, prefetch FIFO and redirect/flush handling.
// Optional macro FETCH_MISALIGN_CHECK_EN halts fetching on a misaligned redirect target.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        fetch_err
);

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] redirect_target;
   logic            run;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   fetch_entry_t    wr_entry;
   fetch_entry_t    head;

   assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
   assign pop      = ~empty & if_ready;
   // A pop frees a slot in the same cycle, which keeps throughput at 1/cycle.
   assign push     = run & (~full | pop) & ~redirect_valid;
   assign wr_entry = '{pc: fetch_pc, instr: imem_rdata};

`ifdef FETCH_MISALIGN_CHECK_EN
   fetch_state_e state;
   fetch_state_e state_next;
   logic         misaligned;

   assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN:     if (misaligned) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = RUN;
      endcase
   end

   assign run       = (state == RUN);
   assign fetch_err = (state == HALT);
`else
   logic unused_low_bits;
   assign unused_low_bits = ^redirect_pc[1:0];
   assign run       = 1'b1;
   assign fetch_err = 1'b0;
`endif

   // In HALT the PC stays frozen even if further redirects arrive.
   always_ff @(posedge clk) begin
      if (!rst_n)                    fetch_pc <= RESET_PC;
      else if (redirect_valid & run) fetch_pc <= redirect_target;
      else if (push)                 fetch_pc <= fetch_pc + PC_STEP;
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .wr_data (wr_entry),
      .full    (full),
      .empty   (empty),
      .head    (head)
   );

   assign imem_addr = fetch_pc;
   assign if_valid  = ~empty;
   assign if_instr  = empty ? INSTR_NOP : head.instr;
   assign if_pc     = empty ? '0 : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch stream queued by the
// stimulus side, consumed and compared by a monitor on every decode handshake.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        fetch_err;

   logic [31:0]  mem [256];
   fetch_entry_t exp_q [$];
   logic [31:0]  stream_pc;
   bit           stream_live = 1'b0;
   bit           halted = 1'b0;
   int           total = 0;
   int           bad = 0;

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr[9:2]];

   instr_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .fetch_err      (fetch_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // The delivered stream after reset or redirect is simply sequential words from the target.
   function automatic void refill();
      while (stream_live && exp_q.size() < 16) begin
         exp_q.push_back('{pc: stream_pc, instr: mem[stream_pc[9:2]]});
         stream_pc = stream_pc + 32'd4;
      end
   endfunction

   function automatic void restart(input logic [31:0] pc);
      exp_q.delete();
      stream_pc   = pc;
      stream_live = 1'b1;
      refill();
   endfunction

   function automatic void kill_stream();
      exp_q.delete();
      stream_live = 1'b0;
   endfunction

   // Monitor
   logic        prev_valid = 1'b0;
   logic        prev_hs    = 1'b0;
   logic        prev_redir = 1'b0;
   logic        prev_rst   = 1'b1;
   logic [31:0] prev_pc    = '0;
   logic [31:0] prev_instr = '0;

   always @(negedge clk) begin
      fetch_entry_t e;
      if (!if_valid) begin
         check("idle_instr", if_instr, INSTR_NOP);
         check("idle_pc", if_pc, 32'h0);
      end
      if (prev_valid && !prev_hs && !prev_redir && !prev_rst) begin
         check("valid_hold", {31'b0, if_valid}, 32'h1);
         check("hold_pc", if_pc, prev_pc);
         check("hold_instr", if_instr, prev_instr);
      end
      if (if_valid && if_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc %h expected no delivery", if_pc);
         end else begin
            e = exp_q.pop_front();
            check("pop_pc", if_pc, e.pc);
            check("pop_instr", if_instr, e.instr);
            refill();
         end
      end
      prev_valid = if_valid;
      prev_hs    = if_valid & if_ready;
      prev_redir = redirect_valid;
      prev_rst   = ~rst_n;
      prev_pc    = if_pc;
      prev_instr = if_instr;
   end

   // Drive one cycle, then update the reference model for the edge just taken.
   task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy, input bit rst);
      redirect_valid = rv;
      redirect_pc    = rpc;
      if_ready       = rdy;
      rst_n          = ~rst;
      @(posedge clk);
      #1;
      if (rst) begin
         halted = 1'b0;
         restart(RST_PC);
      end else if (rv && halted) begin
         exp_q.delete();
      end else if (rv) begin
`ifdef FETCH_MISALIGN_CHECK_EN
         if (rpc[1:0] != 2'b00) begin
            halted = 1'b1;
            kill_stream();
         end else begin
            restart(rpc);
         end
`else
         restart({rpc[31:2], 2'b00});
`endif
      end
   endtask

   initial begin
      bit          rv;
      bit          rdy;
      bit          rst;
      logic [31:0] rpc;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if_ready       = 1'b0;
      rst_n          = 1'b0;

      // Reset values
      repeat (3) step(0, 0, 1, 1);
      check("rst_addr", imem_addr, RST_PC);
      check("rst_valid", {31'b0, if_valid}, 32'h0);
      check("rst_instr", if_instr, INSTR_NOP);
      check("rst_pc", if_pc, 32'h0);
      check("rst_err", {31'b0, fetch_err}, 32'h0);

      // First fetch and sustained 1/cycle delivery
      step(0, 0, 1, 0);
      check("first_valid", {31'b0, if_valid}, 32'h1);
      check("first_pc", if_pc, RST_PC);
      check("first_instr", if_instr, mem[64]);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, 0);
         check("stream_valid", {31'b0, if_valid}, 32'h1);
         check("stream_pc", if_pc, RST_PC + 32'(4 * (i + 1)));
      end

      // Back-pressure: FIFO fills, fetch PC stalls, head holds
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0);
         check("bp_addr", imem_addr, 32'h108);
         check("bp_head", if_pc, 32'h100);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0);
         check("bp_drain_valid", {31'b0, if_valid}, 32'h1);
      end

      // Redirect during a handshake: old entry consumed, one-cycle bubble
      step(1, 32'h10, 0, 0);
      check("redir_bubble0", {31'b0, if_valid}, 32'h0);
      step(0, 0, 0, 0);
      check("redir_head", if_pc, 32'h10);
      step(1, 32'h40, 1, 0);
      check("redir_bubble1", {31'b0, if_valid}, 32'h0);
      step(0, 0, 1, 0);
      check("redir_valid", {31'b0, if_valid}, 32'h1);
      check("redir_target", if_pc, 32'h40);
      repeat (3) step(0, 0, 1, 0);

      // PC wrap-around
      step(1, 32'hFFFF_FFF8, 1, 0);
      step(0, 0, 1, 0);
      check("wrap_first", if_pc, 32'hFFFF_FFF8);
      repeat (4) step(0, 0, 1, 0);

      // Misaligned redirect
      step(1, 32'h22, 1, 0);
      check("mis_addr", imem_addr, 32'h20);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("mis_err", {31'b0, fetch_err}, 32'h1);
      repeat (4) begin
         step(0, 0, 1, 0);
         check("halt_addr", imem_addr, 32'h20);
         check("halt_valid", {31'b0, if_valid}, 32'h0);
         check("halt_err", {31'b0, fetch_err}, 32'h1);
      end
`else
      check("mis_err", {31'b0, fetch_err}, 32'h0);
      step(0, 0, 1, 0);
      check("mis_target", if_pc, 32'h20);
      repeat (4) step(0, 0, 1, 0);
`endif

      // Reset while full with a redirect and handshake pending
      step(0, 0, 1, 1);
      repeat (4) step(0, 0, 0, 0);
      step(1, 32'h80, 1, 1);
      check("rst2_valid", {31'b0, if_valid}, 32'h0);
      check("rst2_addr", imem_addr, RST_PC);
      check("rst2_err", {31'b0, fetch_err}, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rdy = ($urandom_range(3) != 0);
         rv  = ($urandom_range(15) == 0);
         rst = ($urandom_range(299) == 0);
         rpc = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
         rpc[1:0] = 2'b00;
`endif
         step(rv, rpc, rdy, rst);
      end
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
